// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: active-low row drive, synchronised column sampling, frame-level debounce.
// Latency: a steady key map is accepted one clock after DEBOUNCE_FRAMES identical frames complete.
// Backpressure: none; key_valid is a one-cycle pulse and the consumer must take it on that cycle.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  col_in,
    output logic [3:0]  row_out,
    output logic [15:0] key_state,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int MW = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
    localparam logic [MW-1:0] MATCH_MAX  = MW'(DEBOUNCE_FRAMES);
    localparam logic [MW-1:0] MATCH_ONE  = MW'(1);

    // Column synchroniser; idle (all released) is all-ones.
    logic [3:0]    col_meta_q;
    logic [3:0]    col_sync_q;

    // Scan position.
    logic [DW-1:0] dwell_q;
    logic [1:0]    row_q;
    logic [3:0]    row_out_q;

    // Rows 0..2 of the frame in progress; row 3 is taken live on the completing cycle.
    logic [11:0]   frame_q;

    // Debounce state.
    logic [15:0]   cand_q;
    logic [MW-1:0] match_q;

    // Registered outputs.
    logic [15:0]   key_state_q;
    logic [3:0]    key_code_q;
    logic          key_valid_q;
    logic          key_down_q;

    logic          sample;
    logic          frame_done;
    logic [3:0]    cols_pressed;
    logic [15:0]   frame_full;
    logic          commit;
    logic [4:0]    cand_bits;
    logic [3:0]    cand_idx;

    assign sample       = (dwell_q == DWELL_LAST);
    assign frame_done   = sample && (row_q == 2'd3);
    assign cols_pressed = ~col_sync_q;
    assign frame_full   = {cols_pressed, frame_q};
    assign commit       = (match_q == MATCH_MAX) && (cand_q != key_state_q);

    assign row_out   = row_out_q;
    assign key_state = key_state_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

    // Population count and index of the candidate map, used to recognise a lone key press.
    always_comb begin
        cand_bits = 5'd0;
        cand_idx  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (cand_q[i]) begin
                cand_bits = cand_bits + 5'd1;
                cand_idx  = 4'(i);
            end
        end
    end

    // Two-flop synchroniser for the asynchronous column lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q <= 4'b1111;
            col_sync_q <= 4'b1111;
        end else begin
            col_meta_q <= col_in;
            col_sync_q <= col_meta_q;
        end
    end

    // Dwell counter and row rotation; row drive is registered so the pins never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q   <= '0;
            row_q     <= 2'd0;
            row_out_q <= 4'b1110;
        end else if (sample) begin
            dwell_q   <= '0;
            row_q     <= row_q + 2'd1;
            row_out_q <= {row_out_q[2:0], row_out_q[3]};
        end else begin
            dwell_q   <= dwell_q + DWELL_ONE;
        end
    end

    // Capture the pressed columns of rows 0..2 at the end of each row's dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
        end else if (sample) begin
            case (row_q)
                2'd0:    frame_q[3:0]  <= cols_pressed;
                2'd1:    frame_q[7:4]  <= cols_pressed;
                2'd2:    frame_q[11:8] <= cols_pressed;
                default: frame_q       <= frame_q;
            endcase
        end
    end

    // Frame-to-frame debounce: any mismatch restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q  <= '0;
            match_q <= '0;
        end else if (frame_done) begin
            if (frame_full == cand_q) begin
                if (match_q != MATCH_MAX) begin
                    match_q <= match_q + MATCH_ONE;
                end
            end else begin
                cand_q  <= frame_full;
                match_q <= MATCH_ONE;
            end
        end
    end

    // Accept a stable map; report a press only for a lone key arriving from an empty keypad.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_state_q <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (commit) begin
                key_state_q <= cand_q;
                key_down_q  <= (cand_q != 16'd0);
                if ((key_state_q == 16'd0) && (cand_bits == 5'd1)) begin
                    key_valid_q <= 1'b1;
                    key_code_q  <= cand_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=3 (16-cycle frame).
// A behavioural keypad model pulls columns low for pressed keys on the driven row.
// Outputs are sampled on the falling clock edge.
module tb_keypad_scanner;

    logic        clk;
    logic        rst_n;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [15:0] key_state;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;

    logic [15:0] keys;

    int errors;
    int checks;
    int edge_n;
    int pulses;
    int hi_cycles;
    int first_pulse;
    int first_change;
    logic        prev_valid;
    logic [15:0] ks_start;

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_state (key_state),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key shorts its column to the active-low row.
    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
            end
        end
    end

    task automatic clear_counters();
        edge_n       = 0;
        pulses       = 0;
        hi_cycles    = 0;
        first_pulse  = -1;
        first_change = -1;
        prev_valid   = 1'b0;
        ks_start     = key_state;
    endtask

    // Wait for the first cycle of a frame (row 0 following row 3).
    task automatic align();
        logic [3:0] prev;
        int n;
        n = 0;
        do begin
            prev = row_out;
            @(negedge clk);
            n++;
        end while (!(row_out == 4'b1110 && prev == 4'b0111) && n < 200);
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL align_timeout: row_out=%b after %0d cycles, required frame start", row_out, n);
        end
        clear_counters();
    endtask

    // Hold a key map for whole frames while logging key_valid and key_state activity.
    task automatic drive(input logic [15:0] k, input int nframes);
        keys = k;
        repeat (nframes * 16) begin
            @(negedge clk);
            edge_n++;
            if (key_valid) begin
                hi_cycles++;
                if (!prev_valid) pulses++;
                if (first_pulse < 0) first_pulse = edge_n;
            end
            prev_valid = key_valid;
            if (first_change < 0 && key_state !== ks_start) first_change = edge_n;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        keys  = 16'h0000;
        repeat (3) @(negedge clk);
        checks++; if (row_out !== 4'b1110) begin errors++; $display("FAIL reset_row_out: got %b required 1110", row_out); end
        checks++; if (key_state !== 16'h0000) begin errors++; $display("FAIL reset_key_state: got %h required 0000", key_state); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_key_code: got %0d required 0", key_code); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b required 0", key_valid); end
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL reset_key_down: got %b required 0", key_down); end
    endtask

    task automatic test_idle();
        logic [3:0] exp_row;
        int bad_row;
        int bad_out;
        bad_row = 0;
        bad_out = 0;
        rst_n = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            exp_row = ~(4'b0001 << ((i / 4) % 4));
            checks++;
            if (row_out !== exp_row) begin
                errors++;
                $display("FAIL idle_row_out: cycle %0d got %b required %b", i, row_out, exp_row);
            end
            checks++;
            if (key_valid !== 1'b0 || key_state !== 16'h0000) begin
                errors++;
                $display("FAIL idle_outputs: cycle %0d got valid=%b state=%h required 0/0000", i, key_valid, key_state);
            end
        end
    endtask

    task automatic test_single_press();
        align();
        drive(16'h0040, 4);
        checks++; if (first_pulse !== 49) begin errors++; $display("FAIL press_latency: got %0d required 49", first_pulse); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL press_pulses: got %0d required 1", pulses); end
        checks++; if (hi_cycles !== 1) begin errors++; $display("FAIL press_width: got %0d required 1", hi_cycles); end
        checks++; if (key_code !== 4'd6) begin errors++; $display("FAIL press_key_code: got %0d required 6", key_code); end
        checks++; if (key_state !== 16'h0040) begin errors++; $display("FAIL press_key_state: got %h required 0040", key_state); end
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL press_key_down: got %b required 1", key_down); end
    endtask

    task automatic test_release();
        align();
        drive(16'h0000, 4);
        checks++; if (first_change !== 49) begin errors++; $display("FAIL release_latency: got %0d required 49", first_change); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL release_pulses: got %0d required 0", pulses); end
        checks++; if (key_state !== 16'h0000) begin errors++; $display("FAIL release_key_state: got %h required 0000", key_state); end
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL release_key_down: got %b required 0", key_down); end
        checks++; if (key_code !== 4'd6) begin errors++; $display("FAIL release_key_code: got %0d required 6", key_code); end
    endtask

    task automatic test_bounce();
        align();
        for (int f = 0; f < 6; f++) begin
            drive((f % 2 == 0) ? 16'h0040 : 16'h0000, 1);
        end
        checks++; if (pulses !== 0 || key_state !== 16'h0000) begin errors++; $display("FAIL bounce_early_accept: got pulses=%0d state=%h required 0/0000", pulses, key_state); end
        drive(16'h0040, 4);
        checks++; if (first_pulse !== 145) begin errors++; $display("FAIL bounce_latency: got %0d required 145", first_pulse); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL bounce_pulses: got %0d required 1", pulses); end
        checks++; if (key_state !== 16'h0040) begin errors++; $display("FAIL bounce_key_state: got %h required 0040", key_state); end
        drive(16'h0000, 4);
        checks++; if (key_state !== 16'h0000) begin errors++; $display("FAIL bounce_release: got %h required 0000", key_state); end
    endtask

    task automatic test_multi_key();
        align();
        drive(16'h8001, 4);
        checks++; if (first_change !== 49) begin errors++; $display("FAIL multi_latency: got %0d required 49", first_change); end
        checks++; if (key_state !== 16'h8001) begin errors++; $display("FAIL multi_key_state: got %h required 8001", key_state); end
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL multi_key_down: got %b required 1", key_down); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL multi_pulses: got %0d required 0", pulses); end
        drive(16'h0001, 4);
        checks++; if (key_state !== 16'h0001) begin errors++; $display("FAIL partial_key_state: got %h required 0001", key_state); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL partial_pulses: got %0d required 0", pulses); end
        checks++; if (key_code !== 4'd6) begin errors++; $display("FAIL partial_key_code: got %0d required 6", key_code); end
        drive(16'h0000, 4);
        checks++; if (key_state !== 16'h0000 || key_down !== 1'b0) begin errors++; $display("FAIL multi_release: got state=%h down=%b required 0000/0", key_state, key_down); end
    endtask

    task automatic test_reset_mid_debounce();
        align();
        drive(16'h0040, 2);
        repeat (5) @(negedge clk);
        checks++; if (row_out !== 4'b1101) begin errors++; $display("FAIL pre_reset_row: got %b required 1101", row_out); end
        rst_n = 1'b0;
        #1;
        checks++; if (row_out !== 4'b1110) begin errors++; $display("FAIL midreset_row_out: got %b required 1110", row_out); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL midreset_key_code: got %0d required 0", key_code); end
        checks++; if (key_state !== 16'h0000 || key_down !== 1'b0 || key_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: got state=%h down=%b valid=%b required 0000/0/0", key_state, key_down, key_valid);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_counters();
        drive(16'h0040, 4);
        checks++; if (first_pulse !== 49) begin errors++; $display("FAIL midreset_latency: got %0d required 49", first_pulse); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL midreset_pulses: got %0d required 1", pulses); end
        checks++; if (key_code !== 4'd6) begin errors++; $display("FAIL midreset_key_code_after: got %0d required 6", key_code); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        keys   = 16'h0000;
        rst_n  = 1'b0;
        clear_counters();
        test_reset();
        test_idle();
        test_single_press();
        test_release();
        test_bounce();
        test_multi_key();
        test_reset_mid_debounce();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
